// File: rtl/imply_stack.sv
// imply_stack -- LIFO of pending implications (variable index, value).
//
// The conflict detector pushes implications. The solver pops one per cycle to
// drive unit propagation, and flushes the stack on conflict or backtrack.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   push_en       push request (implication from the conflict detector)
//   push_var_idx  implied variable index
//   push_val      implied value
//   pop_en        pop request from the solver
//   flush         discard all entries; overrides push/pop in the same cycle
//   top_valid     stack non-empty, top_* meaningful
//   top_var_idx   variable index of the top entry (0 when empty)
//   top_val       value of the top entry (0 when empty)
//   empty / full  occupancy flags derived from count
//   count         current occupancy (PTR_BITS+1 bits)
//   overflow      sticky flag: a push was dropped because the stack was full
//   dup_drop      (IMPLY_STACK_DEDUP_EN only) one-cycle pulse after a push
//                 was dropped because its variable was already present
//
// Optional feature macro: IMPLY_STACK_DEDUP_EN (adds a presence bitmap that
// drops duplicate pushes of a variable already on the stack).

`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module imply_stack #(
  parameter int DEPTH    = `MAX_VARS,
  parameter int PTR_BITS = `MAX_VARS_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_en,
  input  logic [`MAX_VARS_BITS-1:0] push_var_idx,
  input  logic                      push_val,
  input  logic                      pop_en,
  input  logic                      flush,
  output logic                      top_valid,
  output logic [`MAX_VARS_BITS-1:0] top_var_idx,
  output logic                      top_val,
  output logic                      empty,
  output logic                      full,
  output logic [PTR_BITS:0]         count,
`ifdef IMPLY_STACK_DEDUP_EN
  output logic                      dup_drop,
`endif
  output logic                      overflow
);

  localparam logic [PTR_BITS:0] DEPTH_C = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS:0] ONE_C   = (PTR_BITS + 1)'(1);

  // Storage: no reset needed, contents are qualified by count.
  logic [`MAX_VARS_BITS-1:0] mem_idx_r [DEPTH];
  logic                      mem_val_r [DEPTH];

  logic [PTR_BITS:0]         count_r;
  logic [PTR_BITS:0]         count_nxt_s;
  logic                      overflow_r;
  logic                      overflow_nxt_s;

  logic [PTR_BITS-1:0]       sp_s;
  logic [PTR_BITS-1:0]       top_addr_s;
  logic [`MAX_VARS_BITS-1:0] top_var_s;
  logic                      empty_s;
  logic                      full_s;
  logic                      push_ok_s;
  logic                      wr_en_s;
  logic [PTR_BITS-1:0]       wr_addr_s;

`ifdef IMPLY_STACK_DEDUP_EN
  logic [DEPTH-1:0]          present_r;
  logic [DEPTH-1:0]          present_nxt_s;
  logic                      dup_s;
  logic                      replace_same_s;
  logic                      dup_drop_r;
`endif

  // Pointer arithmetic. When count==DEPTH the low bits wrap to 0, so the
  // top address (sp-1) still lands on the last entry.
  assign sp_s       = count_r[PTR_BITS-1:0];
  assign top_addr_s = sp_s - PTR_BITS'(1);
  assign top_var_s  = mem_idx_r[top_addr_s];
  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == DEPTH_C);

`ifdef IMPLY_STACK_DEDUP_EN
  // Duplicate detection: a push that replaces the same variable in place is
  // not a duplicate, since that variable's entry is leaving the stack.
  always_comb begin
    replace_same_s = pop_en && !empty_s && (push_var_idx == top_var_s);
    if (push_en && present_r[push_var_idx] && !replace_same_s) begin
      dup_s = 1'b1;
    end else begin
      dup_s = 1'b0;
    end
  end
  assign push_ok_s = push_en && !dup_s;
`else
  assign push_ok_s = push_en;
`endif

  // Next-state decode: flush wins, then replace, push, overflow, pop.
  always_comb begin
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    wr_en_s        = 1'b0;
    wr_addr_s      = sp_s;
`ifdef IMPLY_STACK_DEDUP_EN
    present_nxt_s  = present_r;
`endif
    if (flush) begin
      count_nxt_s    = '0;
      overflow_nxt_s = 1'b0;
`ifdef IMPLY_STACK_DEDUP_EN
      present_nxt_s  = '0;
`endif
    end else if (push_ok_s && pop_en && !empty_s) begin
      // Replace in place: old top consumed, new implication becomes top.
      wr_en_s   = 1'b1;
      wr_addr_s = top_addr_s;
`ifdef IMPLY_STACK_DEDUP_EN
      // Clear before set so a same-variable replace keeps its bit.
      present_nxt_s[top_var_s]    = 1'b0;
      present_nxt_s[push_var_idx] = 1'b1;
`endif
    end else if (push_ok_s && !full_s) begin
      wr_en_s     = 1'b1;
      wr_addr_s   = sp_s;
      count_nxt_s = count_r + ONE_C;
`ifdef IMPLY_STACK_DEDUP_EN
      present_nxt_s[push_var_idx] = 1'b1;
`endif
    end else if (push_ok_s) begin
      overflow_nxt_s = 1'b1;
    end else if (pop_en && !empty_s) begin
      count_nxt_s = count_r - ONE_C;
`ifdef IMPLY_STACK_DEDUP_EN
      present_nxt_s[top_var_s] = 1'b0;
`endif
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointer and flag state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r    <= '0;
      overflow_r <= 1'b0;
`ifdef IMPLY_STACK_DEDUP_EN
      present_r  <= '0;
      dup_drop_r <= 1'b0;
`endif
    end else begin
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
`ifdef IMPLY_STACK_DEDUP_EN
      present_r  <= present_nxt_s;
      dup_drop_r <= dup_s && !flush;
`endif
    end
  end

  // Entry storage write port.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_idx_r[wr_addr_s] <= push_var_idx;
      mem_val_r[wr_addr_s] <= push_val;
    end
  end

  // Top-of-stack read, forced to zero when empty.
  always_comb begin
    if (empty_s) begin
      top_var_idx = '0;
      top_val     = 1'b0;
    end else begin
      top_var_idx = top_var_s;
      top_val     = mem_val_r[top_addr_s];
    end
  end

  assign top_valid = !empty_s;
  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = count_r;
  assign overflow  = overflow_r;
`ifdef IMPLY_STACK_DEDUP_EN
  assign dup_drop  = dup_drop_r;
`endif

endmodule

// File: tb/tb_imply_stack.sv
// Self-checking bench for imply_stack: a reference LIFO model produces the
// expected outputs, pushed to a scoreboard queue when stimulus is driven and
// compared after the following clock edge.

`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

module tb_imply_stack;

  localparam int DEPTH = `MAX_VARS;
  localparam int VB    = `MAX_VARS_BITS;

  typedef struct packed {
    logic [VB:0]   count;
    logic          tv;
    logic [VB-1:0] tvar;
    logic          tval;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          dup;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          push_en;
  logic [VB-1:0] push_var_idx;
  logic          push_val;
  logic          pop_en;
  logic          flush;
  logic          top_valid;
  logic [VB-1:0] top_var_idx;
  logic          top_val;
  logic          empty;
  logic          full;
  logic [VB:0]   count;
  logic          overflow;
  logic          dup_drop;

  int            n_vec;
  int            n_fail;
  exp_t          sb_q[$];
  logic [VB:0]   model_q[$];   // entry = {var_idx, val}
  logic          model_ovf;

  imply_stack dut (
    .clock        (clock),
    .reset        (reset),
    .push_en      (push_en),
    .push_var_idx (push_var_idx),
    .push_val     (push_val),
    .pop_en       (pop_en),
    .flush        (flush),
    .top_valid    (top_valid),
    .top_var_idx  (top_var_idx),
    .top_val      (top_val),
    .empty        (empty),
    .full         (full),
    .count        (count),
`ifdef IMPLY_STACK_DEDUP_EN
    .dup_drop     (dup_drop),
`endif
    .overflow     (overflow)
  );

`ifndef IMPLY_STACK_DEDUP_EN
  assign dup_drop = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs from the model's current contents.
  function automatic exp_t snapshot(input logic dup);
    exp_t e;
    logic [VB:0] t;
    e.count = (VB + 1)'(model_q.size());
    e.tv    = (model_q.size() != 0);
    if (model_q.size() != 0) begin
      t = model_q[model_q.size() - 1];
      e.tvar = t[VB:1];
      e.tval = t[0];
    end else begin
      e.tvar = '0;
      e.tval = 1'b0;
    end
    e.empty = (model_q.size() == 0);
    e.full  = (model_q.size() == DEPTH);
    e.ovf   = model_ovf;
    e.dup   = dup;
    return e;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output field.
  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".count"},     int'(count),       int'(e.count));
      chk({tag, ".top_valid"}, int'(top_valid),   int'(e.tv));
      chk({tag, ".top_var"},   int'(top_var_idx), int'(e.tvar));
      chk({tag, ".top_val"},   int'(top_val),     int'(e.tval));
      chk({tag, ".empty"},     int'(empty),       int'(e.empty));
      chk({tag, ".full"},      int'(full),        int'(e.full));
      chk({tag, ".overflow"},  int'(overflow),    int'(e.ovf));
`ifdef IMPLY_STACK_DEDUP_EN
      chk({tag, ".dup_drop"},  int'(dup_drop),    int'(e.dup));
`endif
    end
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input string tag, input logic psh, input int v,
                      input logic val, input logic pp, input logic fl);
    logic dup;
    logic has_top;
    logic [VB:0] ent;
    dup     = 1'b0;
    has_top = (model_q.size() != 0);
    ent     = {VB'(v), val};
    push_en = psh; push_var_idx = VB'(v); push_val = val;
    pop_en  = pp;  flush = fl;
`ifdef IMPLY_STACK_DEDUP_EN
    if (psh && !fl) begin
      foreach (model_q[i]) begin
        if (model_q[i][VB:1] == VB'(v)) dup = 1'b1;
      end
      if (pp && has_top && model_q[model_q.size() - 1][VB:1] == VB'(v)) dup = 1'b0;
    end
`endif
    if (fl) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (psh && !dup && pp && has_top) begin
      model_q[model_q.size() - 1] = ent;
    end else if (psh && !dup && model_q.size() < DEPTH) begin
      model_q.push_back(ent);
    end else if (psh && !dup) begin
      model_ovf = 1'b1;
    end else if (pp && has_top) begin
      void'(model_q.pop_back());
    end
    sb_q.push_back(snapshot(dup));
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; model_ovf = 1'b0;
    push_en = 1'b0; push_var_idx = '0; push_val = 1'b0;
    pop_en = 1'b0; flush = 1'b0;
    reset = 1'b0;
    #2;
    sb_q.push_back(snapshot(1'b0));
    compare("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Three pushes, then three pops.
    step("push5",  1'b1, 5,  1'b1, 1'b0, 1'b0);
    step("push9",  1'b1, 9,  1'b0, 1'b0, 1'b0);
    step("push12", 1'b1, 12, 1'b1, 1'b0, 1'b0);
    step("pop1",   1'b0, 0,  1'b0, 1'b1, 1'b0);
    step("pop2",   1'b0, 0,  1'b0, 1'b1, 1'b0);
    step("pop3",   1'b0, 0,  1'b0, 1'b1, 1'b0);

    // Replace in place with count=2.
    step("rp_a",    1'b1, 5, 1'b1, 1'b0, 1'b0);
    step("rp_b",    1'b1, 9, 1'b0, 1'b0, 1'b0);
    step("replace", 1'b1, 7, 1'b1, 1'b1, 1'b0);
    step("rp_pop",  1'b0, 0, 1'b0, 1'b1, 1'b0);
    step("rp_pop2", 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Fill to DEPTH, overflow, replace while full, flush.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, i, logic'(i % 2), 1'b0, 1'b0);
    end
    step("ovf_push",  1'b1, 3, 1'b0, 1'b0, 1'b0);
    step("ovf_hold",  1'b0, 0, 1'b0, 1'b0, 1'b0);
    step("full_repl", 1'b1, DEPTH - 1, 1'b0, 1'b1, 1'b0);
    step("flush",     1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Empty-stack corner cases.
    step("pop_empty",  1'b0, 0, 1'b0, 1'b1, 1'b0);
    step("pp_empty",   1'b1, 4, 1'b1, 1'b1, 1'b0);

    // Flush beats simultaneous push and pop.
    step("f_a",        1'b1, 6, 1'b0, 1'b0, 1'b0);
    step("f_b",        1'b1, 8, 1'b1, 1'b0, 1'b0);
    step("flush_all",  1'b1, 11, 1'b1, 1'b1, 1'b1);
    step("after_fl",   1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    step("ar_a",       1'b1, 2, 1'b1, 1'b0, 1'b0);
    step("ar_b",       1'b1, 3, 1'b0, 1'b0, 1'b0);
    push_en = 1'b0; pop_en = 1'b0; flush = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    sb_q.push_back(snapshot(1'b0));
    compare("async_rst");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    step("post_rst",   1'b1, 10, 1'b1, 1'b0, 1'b0);
    step("post_pop",   1'b0, 0,  1'b0, 1'b1, 1'b0);

`ifdef IMPLY_STACK_DEDUP_EN
    // Duplicate suppression and same-variable replace.
    step("dd_push",  1'b1, 5, 1'b1, 1'b0, 1'b0);
    step("dd_dup",   1'b1, 5, 1'b0, 1'b0, 1'b0);
    step("dd_idle",  1'b0, 0, 1'b0, 1'b0, 1'b0);
    step("dd_pop",   1'b0, 0, 1'b0, 1'b1, 1'b0);
    step("dd_again", 1'b1, 5, 1'b0, 1'b0, 1'b0);
    step("dd_same",  1'b1, 5, 1'b1, 1'b1, 1'b0);
    step("dd_flush", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step("dd_after", 1'b1, 5, 1'b1, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/imply_stack.md
Name: imply_stack

Overview:
- LIFO buffer of pending implications (variable index, value).
- Written by the conflict detector through a push strobe.
- Read by the solver, which pops one implication per cycle to drive unit propagation.
- The solver flushes it when a conflict is reported or on backtrack.

Parameters:
- DEPTH, default `MAX_VARS: number of entries. At most one implication per variable is outstanding.
- PTR_BITS, default `MAX_VARS_BITS: width of the stack pointer. The occupancy count is PTR_BITS+1 bits.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- push_en  input  1  push request from the conflict detector (its imply_stack_push_en).
- push_var_idx  input  `MAX_VARS_BITS  implied variable index.
- push_val  input  1  implied value.
- pop_en  input  1  pop request from the solver.
- flush  input  1  discard all entries (conflict or backtrack).
- top_valid  output  1  stack non-empty; top_* fields are meaningful.
- top_var_idx  output  `MAX_VARS_BITS  variable index of the top entry.
- top_val  output  1  value of the top entry.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  PTR_BITS+1  current occupancy.
- overflow  output  1  sticky: a push was dropped because the stack was full.

Behaviour:
- Reset (reset low, asynchronous assert): count=0, empty=1, full=0, top_valid=0, top_var_idx=0, top_val=0, overflow=0. Storage contents are don't-care. Release is synchronous to clock.
- Storage: DEPTH entries of {var_idx, val}, plus a pointer sp = count. The top entry is mem[sp-1].
- top_* are a combinational read of the registered state. They update in the same cycle that count changes, i.e. one clock after the push/pop edge. When empty, top_var_idx=0 and top_val=0.
- Priority each cycle: flush > push/pop.
- flush=1: count<=0 and overflow<=0; push_en and pop_en are ignored that cycle. Entries pushed in the flush cycle are lost by design, because the solver discards in-flight implications.
- Push only, not full: mem[sp]<=push entry, count+1.
- Push only, full: entry dropped, count unchanged, overflow<=1.
- Pop only, not empty: count-1. Popped data is the top_* value presented before the edge.
- Pop only, empty: no effect, no error flag.
- Push and pop together, non-empty: the top is replaced in place (mem[sp-1]<=push entry) and count is unchanged. The solver consumes the old top; the new implication becomes the top. Valid even when full; overflow is not set.
- Push and pop together, empty: the pop is ignored and the push proceeds, giving count=1.
- Latency: a push at edge N is visible on top_* after edge N. Minimum back-to-back throughput is one operation per cycle.
- empty/full derive from count. count never exceeds DEPTH and never wraps.
- No internal state machine beyond pointer/flag state. The sticky overflow clears only on flush or reset.

Optional Feature:
- Macro: IMPLY_STACK_DEDUP_EN.
- Defined:
  - Adds a DEPTH-bit presence bitmap indexed by var_idx, plus output dup_drop (1 bit, one-cycle pulse, reset 0).
  - A push whose var_idx is already present is dropped: no storage write, count unchanged, dup_drop=1 the following cycle.
  - The bit is set on an accepted push and cleared on pop of that entry. On replace-in-place, the old var's bit is cleared and the new var's bit is set; if both are the same var, the bit stays set.
  - flush and reset clear the whole bitmap.
  - A dropped duplicate is not treated as a pop. A replace pair is still honoured when the pushed var equals the popped var.
- Undefined: no bitmap and no dup_drop port; duplicates are stored normally.

Test Plan:
- Reset then push (5,1),(9,0),(12,1) on consecutive cycles -> count=3, top=(12,1). Three pops -> tops (9,0), (5,1), then empty=1, top_valid=0.
- With count=2, top=(9,0): push (7,1) and pop in the same cycle -> count=2, top=(7,1). A following pop -> top=(5,1).
- Fill to DEPTH, then push (3,0) -> full=1, count=DEPTH, overflow=1, top unchanged. flush -> count=0, overflow=0, empty=1.
- Pop on empty -> no change. Push (4,1) and pop together on empty -> count=1, top=(4,1).
- With count=3, assert flush, push_en and pop_en together -> count=0 and the pushed entry is absent. Assert reset low mid-sequence (asynchronous, between edges) -> outputs return to reset values immediately.
- IMPLY_STACK_DEDUP_EN: push (5,1), then push (5,0) -> second push dropped, dup_drop pulses, count=1. Pop, then push (5,0) -> accepted, top=(5,0).
